// File: rtl/hdpldadapt_cmn_async_capture_ctrl_if.sv
//------------------------------------------------------------------------------
// hdpldadapt_cmn_async_capture_ctrl_if
//
// Purpose : Bundles the requester handshake and the capture-bus signals of
//           hdpldadapt_cmn_async_capture_ctrl into one interface.
//
// Parameters
//   NREQ    number of requesters sharing the capture bus (1..8)
//   DWIDTH  width of the captured bus
//
// Signals
//   req        requester -> ctrl   per-requester level request, held until ack
//   ack        ctrl -> requester   per-requester one-cycle completion pulse
//   unload     ctrl -> capture     unload strobe to the capture bus
//   capt_data  capture -> ctrl     data_out of the capture bus
//   rdata      ctrl -> requester   captured value returned with ack
//   busy       ctrl -> requester   controller is mid-transaction
//   rdata_par  ctrl -> requester   XOR parity of rdata (only when
//                                  HDPLDADAPT_CAPT_CTRL_PARITY_EN is defined)
//
// Modports
//   master  the capture controller side
//   slave   the requester / capture-bus side
//------------------------------------------------------------------------------
interface hdpldadapt_cmn_async_capture_ctrl_if #(
    parameter int NREQ   = 2,
    parameter int DWIDTH = 8
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   ack;
    logic              unload;
    logic [DWIDTH-1:0] capt_data;
    logic [DWIDTH-1:0] rdata;
    logic              busy;
`ifdef HDPLDADAPT_CAPT_CTRL_PARITY_EN
    logic              rdata_par;

    modport master (
        input  req, capt_data,
        output ack, unload, rdata, busy, rdata_par
    );

    modport slave (
        output req, capt_data,
        input  ack, unload, rdata, busy, rdata_par
    );
`else
    modport master (
        input  req, capt_data,
        output ack, unload, rdata, busy
    );

    modport slave (
        output req, capt_data,
        input  ack, unload, rdata, busy
    );
`endif
endinterface

// File: rtl/hdpldadapt_cmn_async_capture_ctrl.sv
//------------------------------------------------------------------------------
// hdpldadapt_cmn_async_capture_ctrl
//
// Purpose : Arbitrates NREQ requesters onto one capture bus. A granted
//           transaction pulses unload for one cycle, waits SETTLE_CYC cycles
//           for the bus output to settle, captures capt_data into rdata and
//           returns a one-cycle ack to the granted requester. Arbitration is
//           round-robin.
//
// Parameters
//   NREQ        number of requesters (1..8)
//   DWIDTH      captured bus width
//   SETTLE_CYC  cycles unload stays low before data is taken (1..255)
//
// Ports
//   clk    block clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    hdpldadapt_cmn_async_capture_ctrl_if.master
//            req/capt_data in, ack/unload/rdata/busy (and rdata_par) out
//
// Build option
//   HDPLDADAPT_CAPT_CTRL_PARITY_EN  when defined, adds bus.rdata_par, the XOR
//                                   of the captured word, registered with rdata.
//------------------------------------------------------------------------------
module hdpldadapt_cmn_async_capture_ctrl #(
    parameter int NREQ       = 2,
    parameter int DWIDTH     = 8,
    parameter int SETTLE_CYC = 6
) (
    input  logic clk,
    input  logic rst_n,
    hdpldadapt_cmn_async_capture_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNLOAD = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [PTR_W-1:0]  ptr_reg;
    logic [NREQ-1:0]   grant_oh_reg;
    logic              unload_reg;
    logic              busy_reg;
    logic [NREQ-1:0]   ack_reg;
    logic [DWIDTH-1:0] rdata_reg;
`ifdef HDPLDADAPT_CAPT_CTRL_PARITY_EN
    logic              rdata_par_reg;
`endif

    //--------------------------------------------------------------------------
    // Round-robin pick: requests at or above the pointer take priority; if none,
    // wrap around to the lowest request. The lowest set bit of the chosen
    // vector is isolated with x & -x.
    //--------------------------------------------------------------------------
    logic [NREQ-1:0]  low_mask;
    logic [NREQ-1:0]  masked_req;
    logic [NREQ-1:0]  sel_req;
    logic [NREQ-1:0]  win_oh;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] ptr_next;
    logic             req_any;

    assign low_mask   = (NREQ'(1) << ptr_reg) - NREQ'(1);
    assign masked_req = bus.req & ~low_mask;
    assign sel_req    = (masked_req != '0) ? masked_req : bus.req;
    assign win_oh     = sel_req & (~sel_req + NREQ'(1));
    assign req_any    = (bus.req != '0);

    // One-hot to index, built as a running OR so every index is a constant.
    logic [PTR_W-1:0] enc_chain [NREQ+1];
    assign enc_chain[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_enc
            assign enc_chain[gi+1] = enc_chain[gi] | (win_oh[gi] ? PTR_W'(gi) : '0);
        end
    endgenerate

    assign win_idx  = enc_chain[NREQ];
    assign ptr_next = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);

    //--------------------------------------------------------------------------
    // Control FSM with registered outputs. Each output register is set on the
    // edge that enters the state in which it must be visible.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            ptr_reg       <= '0;
            grant_oh_reg  <= '0;
            unload_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            ack_reg       <= '0;
            rdata_reg     <= '0;
`ifdef HDPLDADAPT_CAPT_CTRL_PARITY_EN
            rdata_par_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_any) begin
                        state_reg    <= UNLOAD;
                        grant_oh_reg <= win_oh;
                        ptr_reg      <= ptr_next;
                        unload_reg   <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end
                UNLOAD: begin
                    state_reg  <= WAIT;
                    unload_reg <= 1'b0;
                    cnt_reg    <= CNT_W'(SETTLE_CYC);
                end
                WAIT: begin
                    // Counter holds the number of WAIT cycles still to run,
                    // including the current one.
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg     <= ACK;
                        ack_reg       <= grant_oh_reg;
                        rdata_reg     <= bus.capt_data;
`ifdef HDPLDADAPT_CAPT_CTRL_PARITY_EN
                        rdata_par_reg <= ^bus.capt_data;
`endif
                    end
                end
                ACK: begin
                    state_reg <= IDLE;
                    ack_reg   <= '0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg  <= IDLE;
                    unload_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                    ack_reg    <= '0;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Output drive
    //--------------------------------------------------------------------------
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ack
            assign bus.ack[gi] = ack_reg[gi];
        end
    endgenerate

    assign bus.unload = unload_reg;
    assign bus.busy   = busy_reg;
    assign bus.rdata  = rdata_reg;
`ifdef HDPLDADAPT_CAPT_CTRL_PARITY_EN
    assign bus.rdata_par = rdata_par_reg;
`endif

endmodule

// File: doc/hdpldadapt_cmn_async_capture_ctrl.md
HDPLDADAPT_CMN_ASYNC_CAPTURE_CTRL -- requirements
Module: hdpldadapt_cmn_async_capture_ctrl

Interface
REQ-001 Parameter NREQ, default 2, number of requesters sharing one capture bus; legal range 1..8.
REQ-002 Parameter DWIDTH, default 8, width of the captured bus.
REQ-003 Parameter SETTLE_CYC, default 6, cycles unload stays low before data is taken; legal range 1..255.
REQ-004 clk  input  1  the single block clock, rising-edge only.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  NREQ  per-requester read request, a level held until ack.
REQ-007 ack  output  NREQ  per-requester one-cycle completion pulse.
REQ-008 unload  output  1  drives the capture bus unload input.
REQ-009 capt_data  input  DWIDTH  data_out of the capture bus.
REQ-010 rdata  output  DWIDTH  captured value returned with ack.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 The block SHALL be a four-state FSM: IDLE, UNLOAD, WAIT, ACK.
REQ-013 IDLE with req==0 SHALL stay in IDLE.
REQ-014 IDLE with any req bit set SHALL grant one requester and go to UNLOAD.
REQ-015 Arbitration SHALL be round-robin: search starts at a pointer, the first set bit wins, and the pointer becomes winner+1 modulo NREQ; the pointer resets to 0.
REQ-016 UNLOAD SHALL last exactly 1 cycle with unload=1, then go to WAIT.
REQ-017 WAIT SHALL last exactly SETTLE_CYC cycles with unload=0, counted by a down-counter of width clog2(SETTLE_CYC+1), then go to ACK.
REQ-018 On the WAIT-to-ACK edge, rdata SHALL load capt_data.
REQ-019 rdata SHALL hold its value at all other times.
REQ-020 ACK SHALL last exactly 1 cycle with only the granted ack bit high, then go to IDLE unconditionally.
REQ-021 Because ACK always returns to IDLE, there SHALL be at least one IDLE cycle between transactions.
REQ-022 Latency: if req is sampled in IDLE at edge E, unload SHALL be high from E to E+1, and ack SHALL be high from E+SETTLE_CYC+1 to E+SETTLE_CYC+2.
REQ-023 req SHALL be sampled only in IDLE; changes in other states are ignored.
REQ-024 A requester that drops req mid-transaction SHALL still receive its ack pulse.
REQ-025 A requester that still holds req in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-026 ack SHALL be one-hot or zero in every cycle.
REQ-027 unload and ack SHALL never be high in the same cycle.

Reset
REQ-028 While rst_n=0, the block SHALL force: state=IDLE, unload=0, ack=0, busy=0, rdata all zero, counter=0, RR pointer=0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no ack issued.
REQ-030 After rst_n deasserts, the first req SHALL be sampled no earlier than the first rising clk edge.

Configuration
REQ-031 With macro HDPLDADAPT_CAPT_CTRL_PARITY_EN defined, the block SHALL add output rdata_par (1 bit).
REQ-032 rdata_par SHALL equal the XOR of the loaded capt_data, SHALL be registered on the same edge as rdata, and SHALL reset to 0.
REQ-033 With HDPLDADAPT_CAPT_CTRL_PARITY_EN undefined, rdata_par SHALL be absent and all other behaviour SHALL be identical.

Verification (NREQ=2, DWIDTH=8, SETTLE_CYC=6)
REQ-034 Single read: capt_data=8'hA5, req=2'b01 sampled at edge 0 -> unload high in cycle 0-1, ack=2'b01 in cycle 7-8, rdata=8'hA5, busy low by cycle 8.
REQ-035 Contention: req=2'b11 held -> acks in order 01, 10, 01, with exactly one IDLE cycle between each ACK and the next UNLOAD.
REQ-036 Data change during WAIT: capt_data goes 8'h11 to 8'h22 at WAIT cycle 3 -> rdata=8'h22, taken at WAIT exit.
REQ-037 Reset mid-transaction: rst_n=0 during WAIT -> all outputs go to reset values immediately, no ack pulse; a new req=2'b10 after release completes normally and is granted to requester 1.
REQ-038 Requester drops req during WAIT -> its ack pulse still occurs; no new transaction starts.
REQ-039 Parity build: capt_data=8'h07 -> rdata_par=1; capt_data=8'h03 -> rdata_par=0.
